// File: rtl/harmonic_sum_engine.sv
// Sequential harmonic / alternating-harmonic sum in signed fixed point.
// Each term's reciprocal comes from a bit-serial restoring divider; the accumulator saturates.
module harmonic_sum_engine #(
    parameter int N_W    = 8,
    parameter int FRAC_W = 16,
    parameter int INT_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_W-1:0]          n_in,
    input  logic                    mode,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [INT_W+FRAC_W-1:0] sum,
    output logic                    overflow
);

    // state | meaning
    // IDLE  | waiting for start; sum/overflow hold last result
    // LOAD  | capture n/mode, clear accumulator, i = 1
    // DIV   | FRAC_W+1 cycles of restoring division 2^FRAC_W / i
    // ACC   | add or subtract the reciprocal, advance i
    // DONE  | one-cycle completion pulse

    localparam int S_W = INT_W + FRAC_W;
    localparam int Q_W = FRAC_W + 1;
    localparam int I_W = N_W + 1;
    localparam int A_W = S_W + 2;
    localparam int C_W = $clog2(FRAC_W + 1);

    localparam logic signed [A_W-1:0] SUM_MAX = {{3{1'b0}}, {(S_W-1){1'b1}}};
    localparam logic signed [A_W-1:0] SUM_MIN = {{3{1'b1}}, {(S_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_ACC, S_DONE} state_t;

    state_t                 state_q;
    logic [N_W-1:0]         n_q;
    logic                   mode_q;
    logic [I_W-1:0]         i_q;
    logic [I_W-1:0]         rem_q;
    logic [Q_W-1:0]         quot_q;
    logic [C_W-1:0]         cnt_q;
    logic signed [S_W-1:0]  sum_q;
    logic                   ovf_q;

    logic [I_W:0]           rem_sh;
    logic [I_W-1:0]         rem_d;
    logic [Q_W-1:0]         quot_d;
    logic signed [A_W-1:0]  acc;
    logic signed [S_W-1:0]  sum_d;
    logic                   sat;
    logic [I_W-1:0]         i_nx;
    logic                   last_term;

    always_comb begin
        // The dividend 2^FRAC_W has a single 1 in its MSB, which enters on the first DIV cycle.
        rem_sh = {rem_q, (cnt_q == C_W'(FRAC_W))};
        rem_d  = rem_sh[I_W-1:0];
        quot_d = {quot_q[Q_W-2:0], 1'b0};
        if (rem_sh >= {1'b0, i_q}) begin
            rem_d  = I_W'(rem_sh - {1'b0, i_q});
            quot_d = {quot_q[Q_W-2:0], 1'b1};
        end

        if (mode_q && !i_q[0])
            acc = {{2{sum_q[S_W-1]}}, sum_q} - {{(A_W-Q_W){1'b0}}, quot_q};
        else
            acc = {{2{sum_q[S_W-1]}}, sum_q} + {{(A_W-Q_W){1'b0}}, quot_q};

        sat   = 1'b0;
        sum_d = acc[S_W-1:0];
        if (acc > SUM_MAX) begin
            sat   = 1'b1;
            sum_d = {1'b0, {(S_W-1){1'b1}}};
        end else if (acc < SUM_MIN) begin
            sat   = 1'b1;
            sum_d = {1'b1, {(S_W-1){1'b0}}};
        end

        i_nx      = i_q + I_W'(1);
        last_term = i_nx > {1'b0, n_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            mode_q  <= 1'b0;
            i_q     <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        n_q     <= n_in;
                        mode_q  <= mode;
                    end
                end
                S_LOAD: begin
                    sum_q <= '0;
                    ovf_q <= 1'b0;
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        i_q     <= I_W'(1);
                        rem_q   <= '0;
                        quot_q  <= '0;
                        cnt_q   <= C_W'(FRAC_W);
                        state_q <= (n_q == '0) ? S_DONE : S_DIV;
                    end
                end
                S_DIV: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        sum_q   <= '0;
                        ovf_q   <= 1'b0;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        cnt_q  <= cnt_q - C_W'(1);
                        if (cnt_q == '0)
                            state_q <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        sum_q   <= '0;
                        ovf_q   <= 1'b0;
                    end else begin
                        sum_q   <= sum_d;
                        ovf_q   <= ovf_q | sat;
                        i_q     <= i_nx;
                        rem_q   <= '0;
                        quot_q  <= '0;
                        cnt_q   <= C_W'(FRAC_W);
                        state_q <= last_term ? S_DONE : S_DIV;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign overflow = ovf_q;

endmodule
